// File: rtl/dispatch_pkg.sv
// Shared types for the work-dispatch path.
//   collector_state_t : result-collector FSM states
//   pixel_result_t    : one worker result, tagged with its (x,y) coordinate
//   FRAME_W/FRAME_H   : default frame geometry; FRAME_PIXELS = FRAME_W*FRAME_H
//   X_BITS/Y_BITS/D_BITS : field widths of pixel_result_t
package dispatch_pkg;

  localparam int X_BITS       = 10;
  localparam int Y_BITS       = 9;
  localparam int D_BITS       = 8;
  localparam int FRAME_W      = 640;
  localparam int FRAME_H      = 480;
  localparam int FRAME_PIXELS = FRAME_W * FRAME_H;

  typedef enum logic [1:0] {IDLE, RUN, WRITE, DONE} collector_state_t;

  typedef struct packed {
    logic [X_BITS-1:0] x;
    logic [Y_BITS-1:0] y;
    logic [D_BITS-1:0] data;
  } pixel_result_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO.
//   clk, n_rst       : clock, async active-low reset
//   flush_i          : empties the FIFO (has priority over push/pop)
//   push_i, din_i    : write an entry; ignored while full
//   pop_i, dout_o    : dout_o always shows the head; pop_i drops it (ignored while empty)
//   full_o, empty_o  : occupancy flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra pointer bit distinguishes full from empty when indices match.
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/pixel_result_collector.sv
// Sink of the work-dispatch path: buffers (x,y)-tagged worker results and
// writes each to the frame buffer at y*FRAME_W + x.
//   clk, n_rst            : clock, async active-low reset
//   frame_start           : pulse in IDLE/DONE arms a new frame (flushes FIFO, clears counters)
//   res_valid/res_ready   : result handshake; res_x, res_y, res_data carry the result
//   mem_wr_req/mem_ack    : frame-buffer write handshake; mem_addr, mem_wdata held while requesting
//   pixel_count           : writes completed this frame (saturating)
//   frame_done            : all FRAME_W*FRAME_H writes completed
//   range_err             : sticky, an out-of-frame coordinate was dropped
module pixel_result_collector
  import dispatch_pkg::*;
#(
  parameter int NUM_X_BITS = X_BITS,
  parameter int NUM_Y_BITS = Y_BITS,
  parameter int FRAME_W    = dispatch_pkg::FRAME_W,
  parameter int FRAME_H    = dispatch_pkg::FRAME_H,
  parameter int DATA_BITS  = D_BITS,
  parameter int ADDR_BITS  = 19,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  frame_start,
  input  logic                  res_valid,
  output logic                  res_ready,
  input  logic [NUM_X_BITS-1:0] res_x,
  input  logic [NUM_Y_BITS-1:0] res_y,
  input  logic [DATA_BITS-1:0]  res_data,
  output logic                  mem_wr_req,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_BITS-1:0]  mem_wdata,
  input  logic                  mem_ack,
  output logic [ADDR_BITS-1:0]  pixel_count,
  output logic                  frame_done,
  output logic                  range_err
);

  // The FIFO entry type is fixed by the package, so the port widths must match it.
  if (NUM_X_BITS != X_BITS || NUM_Y_BITS != Y_BITS || DATA_BITS != D_BITS) begin : g_width_chk
    $error("pixel_result_collector: coordinate/data widths must match dispatch_pkg");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("pixel_result_collector: FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if ((64'd1 << ADDR_BITS) < 64'(FRAME_W) * 64'(FRAME_H)) begin : g_addr_chk
    $error("pixel_result_collector: ADDR_BITS too small for the frame");
  end

  localparam logic [NUM_X_BITS:0] X_LIM  = (NUM_X_BITS+1)'(FRAME_W);
  localparam logic [NUM_Y_BITS:0] Y_LIM  = (NUM_Y_BITS+1)'(FRAME_H);
  localparam logic [ADDR_BITS-1:0] W_MUL = ADDR_BITS'(FRAME_W);
  // Count compare is one bit wider so a frame filling the whole address space still terminates.
  localparam logic [ADDR_BITS:0] PIX_LIM = (ADDR_BITS+1)'(FRAME_W * FRAME_H);
  localparam logic [ADDR_BITS:0] CNT_ONE = 1;

  collector_state_t state_q, state_d;
  logic                 req_q, req_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [ADDR_BITS-1:0] cnt_q, cnt_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;

  pixel_result_t        in_res, head;
  logic                 fifo_full, fifo_empty;
  logic                 active, in_range, accept, push, pop, flush;
  logic [ADDR_BITS-1:0] head_addr;
  logic [ADDR_BITS:0]   cnt_inc;

  assign in_res    = {res_x, res_y, res_data};
  assign active    = (state_q == RUN) || (state_q == WRITE);
  assign res_ready = active & ~fifo_full;
  assign in_range  = ({1'b0, res_x} < X_LIM) && ({1'b0, res_y} < Y_LIM);
  assign accept    = res_valid & res_ready;
  // Out-of-frame results complete the handshake but are never buffered.
  assign push      = accept & in_range;
  assign pop       = (state_q == RUN) & ~fifo_empty;
  assign flush     = ((state_q == IDLE) || (state_q == DONE)) & frame_start;

  assign head_addr = ADDR_BITS'(head.y) * W_MUL + ADDR_BITS'(head.x);
  assign cnt_inc   = {1'b0, cnt_q} + CNT_ONE;

  sync_fifo #(
    .WIDTH ($bits(pixel_result_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .flush_i (flush),
    .push_i  (push),
    .din_i   (in_res),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    done_d  = done_q;
    err_d   = err_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE, DONE: begin
        if (frame_start) begin
          state_d = RUN;
          cnt_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      RUN: begin
        if (!fifo_empty) begin
          state_d = WRITE;
          req_d   = 1'b1;
          addr_d  = head_addr;
          wdata_d = head.data;
        end
      end
      WRITE: begin
        // Returning to RUN for a cycle keeps each write at >= 2 cycles.
        if (mem_ack) begin
          req_d = 1'b0;
          if (cnt_inc >= PIX_LIM) begin
            cnt_d   = PIX_LIM[ADDR_BITS-1:0];
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            cnt_d   = cnt_inc[ADDR_BITS-1:0];
            state_d = RUN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Accepts only happen in RUN/WRITE, so this never collides with the clear above.
    if (accept && !in_range) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      done_q  <= done_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_wr_req  = req_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign pixel_count = cnt_q;
  assign frame_done  = done_q;
  assign range_err   = err_q;

endmodule

// File: tb/tb_pixel_result_collector.sv
// Directed bench for pixel_result_collector on a 4x2 frame with a 4-entry FIFO.
module tb_pixel_result_collector;

  localparam int XB = 10, YB = 9, DB = 8, AB = 19;

  logic          clk = 1'b0, n_rst = 1'b0;
  logic          frame_start = 1'b0, res_valid = 1'b0, mem_ack = 1'b0;
  logic [XB-1:0] res_x = '0;
  logic [YB-1:0] res_y = '0;
  logic [DB-1:0] res_data = '0;
  logic          res_ready, mem_wr_req, frame_done, range_err;
  logic [AB-1:0] mem_addr, pixel_count;
  logic [DB-1:0] mem_wdata;

  int n_cmp = 0, n_err = 0;
  int cap_a[$], cap_d[$];

  pixel_result_collector #(
    .NUM_X_BITS (XB), .NUM_Y_BITS (YB), .FRAME_W (4), .FRAME_H (2),
    .DATA_BITS (DB), .ADDR_BITS (AB), .FIFO_DEPTH (4)
  ) dut (
    .clk (clk), .n_rst (n_rst), .frame_start (frame_start),
    .res_valid (res_valid), .res_ready (res_ready),
    .res_x (res_x), .res_y (res_y), .res_data (res_data),
    .mem_wr_req (mem_wr_req), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
    .mem_ack (mem_ack), .pixel_count (pixel_count),
    .frame_done (frame_done), .range_err (range_err)
  );

  always #5 clk = ~clk;

  // Log every write that completes at the coming edge.
  always @(negedge clk) begin
    if (n_rst && mem_wr_req && mem_ack) begin
      cap_a.push_back(int'(mem_addr));
      cap_d.push_back(int'(mem_wdata));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 32'(res_ready), 0);
    chk({tag, "_req"},   32'(mem_wr_req), 0);
    chk({tag, "_addr"},  32'(mem_addr), 0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 0);
    chk({tag, "_cnt"},   32'(pixel_count), 0);
    chk({tag, "_done"},  32'(frame_done), 0);
    chk({tag, "_err"},   32'(range_err), 0);
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    tick();
    tick();
    n_rst = 1'b1;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic push(input int x, input int y, input int d);
    bit ok = 1'b0;
    res_valid = 1'b1;
    res_x = XB'(x);
    res_y = YB'(y);
    res_data = DB'(d);
    for (int i = 0; i < 50 && !ok; i++) begin
      if (res_ready) ok = 1'b1;
      tick();
    end
    res_valid = 1'b0;
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && !mem_wr_req; i++) tick();
    chk("wait_req", 32'(mem_wr_req), 1);
  endtask

  task automatic chk_caps(input string tag, input int exp_a[$], input int exp_d[$]);
    chk({tag, "_nwr"}, 32'(cap_a.size()), 32'(exp_a.size()));
    for (int i = 0; i < exp_a.size(); i++) begin
      chk({tag, "_addr"}, (i < cap_a.size()) ? 32'(cap_a[i]) : 32'hFFFF_FFFF, 32'(exp_a[i]));
      chk({tag, "_data"}, (i < cap_d.size()) ? 32'(cap_d[i]) : 32'hFFFF_FFFF, 32'(exp_d[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    n_rst = 1'b0;
    tick();
    tick();
    chk_zero("rst");
    n_rst = 1'b1;

    // Idle: valid without frame_start is not accepted
    res_valid = 1'b1; res_x = 1; res_y = 0; res_data = 8'h33;
    repeat (3) tick();
    chk("idle_ready", 32'(res_ready), 0);
    chk("idle_req",   32'(mem_wr_req), 0);
    chk("idle_cnt",   32'(pixel_count), 0);
    res_valid = 1'b0;

    // Single write with 3 wait cycles
    start_frame();
    chk("sw_ready", 32'(res_ready), 1);
    cap_a.delete(); cap_d.delete();
    push(3, 1, 8'hA5);
    chk("sw_lat1_req", 32'(mem_wr_req), 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("sw_hold_req",   32'(mem_wr_req), 1);
      chk("sw_hold_addr",  32'(mem_addr), 7);
      chk("sw_hold_wdata", 32'(mem_wdata), 32'hA5);
      if (i < 2) tick();
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("sw_req_drop", 32'(mem_wr_req), 0);
    chk("sw_cnt",      32'(pixel_count), 1);
    chk("sw_run",      32'(res_ready), 1);
    chk_caps("sw", '{7}, '{8'hA5});
    // frame_start mid-frame has no effect
    start_frame();
    chk("ign_fs_cnt",   32'(pixel_count), 1);
    chk("ign_fs_ready", 32'(res_ready), 1);

    // Full frame, ack tied high
    do_reset();
    start_frame();
    cap_a.delete(); cap_d.delete();
    mem_ack = 1'b1;
    for (int i = 0; i < 8; i++) push(i % 4, i / 4, 8'h10 + i);
    for (int i = 0; i < 50 && !frame_done; i++) tick();
    chk("ff_done",  32'(frame_done), 1);
    chk("ff_cnt",   32'(pixel_count), 8);
    chk("ff_ready", 32'(res_ready), 0);
    chk_caps("ff", '{0, 1, 2, 3, 4, 5, 6, 7},
             '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17});
    repeat (3) tick();
    chk("ff_done_hold", 32'(frame_done), 1);
    chk("ff_ready_hold", 32'(res_ready), 0);
    chk("ff_req_idle",  32'(mem_wr_req), 0);
    mem_ack = 1'b0;

    // Backpressure: restart from DONE, stall ack, fill FIFO
    start_frame();
    chk("bp_cnt_clr",  32'(pixel_count), 0);
    chk("bp_done_clr", 32'(frame_done), 0);
    cap_a.delete(); cap_d.delete();
    push(1, 0, 8'hB0);
    push(2, 1, 8'hB1);
    push(0, 1, 8'hB2);
    push(3, 0, 8'hB3);
    push(1, 1, 8'hB4);
    chk("bp_full_ready", 32'(res_ready), 0);
    chk("bp_req",        32'(mem_wr_req), 1);
    chk("bp_addr",       32'(mem_addr), 1);
    chk("bp_wdata",      32'(mem_wdata), 32'hB0);
    mem_ack = 1'b1;
    for (int i = 0; i < 50 && pixel_count != 5; i++) tick();
    mem_ack = 1'b0;
    chk("bp_cnt", 32'(pixel_count), 5);
    chk_caps("bp", '{1, 6, 4, 3, 5}, '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4});

    // Reset while a write is outstanding
    push(2, 0, 8'h77);
    wait_req();
    #3 n_rst = 1'b0;
    #1 chk_zero("rstw");
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    res_valid = 1'b1; res_x = 0; res_y = 0; res_data = 8'h11;
    repeat (2) tick();
    chk("rstw_ready_low", 32'(res_ready), 0);
    chk("rstw_req_low",   32'(mem_wr_req), 0);
    res_valid = 1'b0;
    start_frame();
    chk("rstw_ready_back", 32'(res_ready), 1);

    // Range errors: dropped, sticky flag, next valid result still written
    cap_a.delete(); cap_d.delete();
    push(4, 0, 8'h01);
    push(0, 2, 8'h02);
    tick();
    chk("re_err", 32'(range_err), 1);
    chk("re_cnt", 32'(pixel_count), 0);
    chk("re_req", 32'(mem_wr_req), 0);
    push(0, 0, 8'h5A);
    wait_req();
    chk("re_addr",  32'(mem_addr), 0);
    chk("re_wdata", 32'(mem_wdata), 32'h5A);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("re_cnt_after", 32'(pixel_count), 1);
    chk("re_err_sticky", 32'(range_err), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
